// File: rtl/ai_pkg.sv
// Shared AI-path definitions: board geometry, cell/row/col/density types and
// the target-select state encoding. Feature macro: AI_PARITY_EN.
package ai_pkg;
    localparam int N_CELLS = 100;
    localparam int GRID_W  = 10;
    localparam int DW      = 6;
    localparam int IDX_W   = 7;
    localparam int RC_W    = 4;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [RC_W-1:0]  rc_t;
    typedef logic [DW-1:0]    den_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
`ifdef AI_PARITY_EN
        ST_SCAN2,
`endif
        ST_DONE
    } state_t;
endpackage

// File: rtl/ai_cell_cursor.sv
// Board cursor: row-major idx/row/col counters with column wrap, a last-cell
// flag and a running (row+col) odd-parity bit, so no divider is needed.
module ai_cell_cursor
    import ai_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output idx_t idx,
    output rc_t  row,
    output rc_t  col,
    output logic last,
    output logic odd
);

    // Counter update; a column wrap changes row+col by -8, so parity holds there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            row <= '0;
            col <= '0;
            odd <= 1'b0;
        end else if (clear) begin
            idx <= '0;
            row <= '0;
            col <= '0;
            odd <= 1'b0;
        end else if (advance) begin
            idx <= idx + idx_t'(1);
            if (col == rc_t'(GRID_W - 1)) begin
                col <= '0;
                row <= row + rc_t'(1);
            end else begin
                col <= col + rc_t'(1);
                odd <= ~odd;
            end
        end
    end

    assign last = (idx == idx_t'(N_CELLS - 1));

endmodule

// File: rtl/ai_target_select.sv
// Scans the density map one cell per clock and presents the densest unfired
// cell as a shot target over valid/ready. Feature macro: AI_PARITY_EN adds a
// checkerboard-only first pass with a full fallback rescan.
module ai_target_select
    import ai_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_CELLS-1:0][DW-1:0] density,
    input  logic [N_CELLS-1:0]         fired,
    output logic                       busy,
    output logic                       target_valid,
    input  logic                       target_ready,
    output idx_t                       target_idx,
    output rc_t                        target_row,
    output rc_t                        target_col,
    output den_t                       target_density,
    output logic                       no_target
);

    state_t state, state_nx;
    idx_t   cur_idx;
    rc_t    cur_row, cur_col;
    logic   cur_last, cur_odd;
    logic   clear_cur, finish, scanning, start_acc;
    logic   parity_ok, candidate, accept, found_nx;
    den_t   cur_den;

    idx_t   best_idx;
    rc_t    best_row, best_col;
    den_t   best_den;
    logic   best_found;

    ai_cell_cursor u_cursor (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_cur),
        .advance (scanning & ~cur_last),
        .idx     (cur_idx),
        .row     (cur_row),
        .col     (cur_col),
        .last    (cur_last),
        .odd     (cur_odd)
    );

`ifdef AI_PARITY_EN
    assign scanning  = (state == ST_SCAN) || (state == ST_SCAN2);
    assign parity_ok = (state == ST_SCAN) ? ~cur_odd : 1'b1;
`else
    logic unused_odd;
    assign unused_odd = cur_odd;
    assign scanning   = (state == ST_SCAN);
    assign parity_ok  = 1'b1;
`endif

    assign busy      = scanning;
    assign start_acc = (state == ST_IDLE) && start;
    assign cur_den   = density[cur_idx];
    assign candidate = scanning && !fired[cur_idx] && parity_ok;
    // Strict compare keeps the lowest index on ties.
    assign accept    = candidate && (!best_found || (cur_den > best_den));
    assign found_nx  = best_found || accept;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic, cursor restart and end-of-scan strobe.
    always_comb begin
        state_nx  = state;
        clear_cur = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx  = ST_SCAN;
                    clear_cur = 1'b1;
                end
            end
            ST_SCAN: begin
                if (cur_last) begin
`ifdef AI_PARITY_EN
                    if (found_nx) begin
                        state_nx = ST_DONE;
                        finish   = 1'b1;
                    end else begin
                        state_nx  = ST_SCAN2;
                        clear_cur = 1'b1;
                    end
`else
                    state_nx = ST_DONE;
                    finish   = 1'b1;
`endif
                end
            end
`ifdef AI_PARITY_EN
            ST_SCAN2: begin
                if (cur_last) begin
                    state_nx = ST_DONE;
                    finish   = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                if (target_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Best-so-far tracking, cleared when a scan is started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_idx   <= '0;
            best_row   <= '0;
            best_col   <= '0;
            best_den   <= '0;
            best_found <= 1'b0;
        end else if (start_acc) begin
            best_idx   <= '0;
            best_row   <= '0;
            best_col   <= '0;
            best_den   <= '0;
            best_found <= 1'b0;
        end else if (accept) begin
            best_idx   <= cur_idx;
            best_row   <= cur_row;
            best_col   <= cur_col;
            best_den   <= cur_den;
            best_found <= 1'b1;
        end
    end

    // Result registers: loaded with the final cell folded in, held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_valid   <= 1'b0;
            no_target      <= 1'b0;
            target_idx     <= '0;
            target_row     <= '0;
            target_col     <= '0;
            target_density <= '0;
        end else if (finish) begin
            target_valid   <= 1'b1;
            no_target      <= ~found_nx;
            target_idx     <= accept ? cur_idx : best_idx;
            target_row     <= accept ? cur_row : best_row;
            target_col     <= accept ? cur_col : best_col;
            target_density <= accept ? cur_den : best_den;
        end else if ((state == ST_DONE) && target_ready) begin
            target_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ai_target_select.sv
// Self-checking bench for ai_target_select: directed maps with literal
// expectations plus a per-cycle comparison against an argmax reference model.
module tb_ai_target_select;
    import ai_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic [N_CELLS-1:0][DW-1:0] density = '0;
    logic [N_CELLS-1:0]         fired = '0;
    logic                       busy, target_valid, no_target;
    logic                       target_ready = 1'b0;
    idx_t                       target_idx;
    rc_t                        target_row, target_col;
    den_t                       target_density;

    int checks = 0;
    int errors = 0;

    ai_target_select dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .density        (density),
        .fired          (fired),
        .busy           (busy),
        .target_valid   (target_valid),
        .target_ready   (target_ready),
        .target_idx     (target_idx),
        .target_row     (target_row),
        .target_col     (target_col),
        .target_density (target_density),
        .no_target      (no_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: densest unfired cell, lowest index on ties; -1 if none.
    function automatic int search(input bit even_only);
        int best = -1;
        for (int i = 0; i < N_CELLS; i++) begin
            if (fired[i]) continue;
            if (even_only && (((i / GRID_W) + (i % GRID_W)) % 2 != 0)) continue;
            if (best < 0 || int'(density[i]) > int'(density[best])) best = i;
        end
        return best;
    endfunction

    function automatic int pick();
`ifdef AI_PARITY_EN
        int r = search(1'b1);
        if (r < 0) r = search(1'b0);
        return r;
`else
        return search(1'b0);
`endif
    endfunction

    function automatic int pick_lat();
`ifdef AI_PARITY_EN
        return (search(1'b1) < 0) ? 2 * N_CELLS + 1 : N_CELLS + 1;
`else
        return N_CELLS + 1;
`endif
    endfunction

    int m_phase = 0;
    int m_cnt   = 0;
    bit m_busy  = 0;
    bit m_valid = 0;
    bit m_none  = 0;
    int m_idx   = 0;
    int m_den   = 0;

    // Transaction-level model: latency countdown then the argmax result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_busy  <= 0;
            m_valid <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_busy  <= 1;
                    m_cnt   <= pick_lat() - 1;
                    m_none  <= (pick() < 0);
                    m_idx   <= (pick() < 0) ? 0 : pick();
                    m_den   <= (pick() < 0) ? 0 : int'(density[pick()]);
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_busy  <= 0;
                        m_valid <= 1;
                        m_phase <= 2;
                    end
                end
                default: if (target_ready) begin
                    m_valid <= 0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("busy", int'(busy), int'(m_busy));
        chk("valid", int'(target_valid), int'(m_valid));
        if (m_valid && target_valid) begin
            chk("m_idx", int'(target_idx), m_idx);
            chk("m_row", int'(target_row), m_idx / GRID_W);
            chk("m_col", int'(target_col), m_idx % GRID_W);
            chk("m_den", int'(target_density), m_den);
            chk("m_none", int'(no_target), int'(m_none));
        end
    end

    // Pulse start, return edges from the accepting edge to target_valid.
    task automatic run_scan(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        while (!target_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!target_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic accept_result();
        @(negedge clk);
        target_ready = 1'b1;
        @(posedge clk);
        #1;
        target_ready = 1'b0;
        chk("valid_drop", int'(target_valid), 0);
    endtask

    task automatic expect_tgt(input string name, input int idx, input int den, input int none);
        chk({name, "_idx"}, int'(target_idx), idx);
        chk({name, "_row"}, int'(target_row), idx / GRID_W);
        chk({name, "_col"}, int'(target_col), idx % GRID_W);
        chk({name, "_den"}, int'(target_density), den);
        chk({name, "_none"}, int'(no_target), none);
    endtask

    initial begin
        int lat;
        int seen;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(target_valid), 0);
        chk("rst_idx", int'(target_idx), 0);
        chk("rst_none", int'(no_target), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single hot cell.
        density = '0; fired = '0;
        density[57] = 6'd20;
        run_scan(lat);
        chk("t1_lat", lat, 101);
        chk("t1_idx", int'(target_idx), 57);
        chk("t1_row", int'(target_row), 5);
        chk("t1_col", int'(target_col), 7);
        chk("t1_den", int'(target_density), 20);
        chk("t1_none", int'(no_target), 0);
        accept_result();

        // Tie plus fired exclusion.
        density = '0; fired = '0;
        density[12] = 6'd30; density[88] = 6'd30; density[3] = 6'd40; fired[3] = 1'b1;
        run_scan(lat);
        chk("t2_lat", lat, 101);
`ifdef AI_PARITY_EN
        expect_tgt("t2", 88, 30, 0);
`else
        expect_tgt("t2", 12, 30, 0);
`endif
        accept_result();

        // Everything fired.
        density = '1; fired = '1;
        run_scan(lat);
`ifdef AI_PARITY_EN
        chk("t3_lat", lat, 201);
`else
        chk("t3_lat", lat, 101);
`endif
        expect_tgt("t3", 0, 0, 1);
        accept_result();

        // Back-pressure: hold ready low, starts ignored.
        density = '0; fired = '0;
        density[44] = 6'd33;
        run_scan(lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = (k % 2 == 0);
            @(posedge clk);
            #1;
            chk("hold_valid", int'(target_valid), 1);
            chk("hold_idx", int'(target_idx), 44);
            chk("hold_den", int'(target_density), 33);
        end
        @(negedge clk);
        start = 1'b0;
        accept_result();
        chk("kept_idx", int'(target_idx), 44);
        @(posedge clk);
        #1;
        chk("no_queued_start", int'(busy), 0);

        // Restart with ready held high throughout.
        density[99] = 6'd63;
        @(negedge clk);
        target_ready = 1'b1;
        run_scan(lat);
        chk("t5_lat", lat, 101);
        expect_tgt("t5", 99, 63, 0);
        @(posedge clk);
        #1;
        chk("t5_drop", int'(target_valid), 0);
        target_ready = 1'b0;

        // Reset in the middle of a scan.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(target_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (target_valid || busy) seen++;
        end
        chk("no_result_after_rst", seen, 0);

        // All-zero density picks the lowest unfired cell.
        density = '0; fired = '0;
        fired[0] = 1'b1; fired[1] = 1'b1;
        run_scan(lat);
        expect_tgt("t7", 2, 0, 0);
        accept_result();

        // Only an odd-parity cell remains.
        density = '0; fired = '1;
        fired[1] = 1'b0; density[1] = 6'd9;
        run_scan(lat);
`ifdef AI_PARITY_EN
        chk("t8_lat", lat, 201);
`else
        chk("t8_lat", lat, 101);
`endif
        expect_tgt("t8", 1, 9, 0);
        accept_result();

        // Even cell beats a denser odd cell only with the checkerboard filter.
        density = '0; fired = '1;
        fired[0] = 1'b0; fired[1] = 1'b0;
        density[0] = 6'd2; density[1] = 6'd50;
        run_scan(lat);
        chk("t9_lat", lat, 101);
`ifdef AI_PARITY_EN
        expect_tgt("t9", 0, 2, 0);
`else
        expect_tgt("t9", 1, 50, 0);
`endif
        accept_result();

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
